cipher_sequencer: RTL
=====================

CIPHER_SEQUENCER -- requirements
Module: cipher_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: maximum cycles WAIT waits for core_done; only used when CSEQ_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pair_valid  input  1  one-cycle pulse: msg/key pair valid this cycle.
REQ-005 msg  input  128  plaintext block.
REQ-006 key  input  128  key block.
REQ-007 core_done  input  1  one-cycle pulse from cipher core: result valid.
REQ-008 core_dout  input  128  cipher core result.
REQ-009 tx_busy  input  1  UART transmitter busy; goes high the cycle after tx_start and stays high until the byte is sent.
REQ-010 core_start  output  1  one-cycle start pulse to cipher core.
REQ-011 core_din  output  128  block presented to core; registered.
REQ-012 core_key  output  128  key presented to core; registered.
REQ-013 tx_start  output  1  one-cycle pulse requesting transmission of tx_byte.
REQ-014 tx_byte  output  8  byte to transmit; registered, stable from tx_start until the next tx_start.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 drop_cnt  output  8  count of discarded pairs; saturates at 255.
REQ-017 timeout_err  output  1  sticky core-timeout flag; tied 0 when CSEQ_TIMEOUT_EN is undefined.

Function
REQ-018 FSM states: IDLE, START, WAIT, SEND, TXWAIT. No other states.
REQ-019 Pending buffer: one 256-bit slot with a valid bit, pend_v.
REQ-020 IDLE, pair_valid=1: latch msg/key into core_din/core_key; go to START next cycle.
REQ-021 IDLE, pend_v=1, no pair_valid: load pending into core_din/core_key; clear pend_v; go to START.
REQ-022 IDLE, pair_valid=1 and pend_v=1 together: load pending first; store the new pair in the slot (pend_v stays 1).
REQ-023 START: assert core_start for exactly one cycle; go to WAIT.
REQ-024 WAIT, core_done=1: capture core_dout into a 128-bit shift register; set byte index to 0; go to SEND.
REQ-025 core_done outside WAIT is ignored.
REQ-026 SEND, tx_busy=0: drive tx_byte = shift[127:120] and pulse tx_start; go to TXWAIT. SEND with tx_busy=1 holds.
REQ-027 TXWAIT: ignore tx_busy on the first cycle; afterwards, when tx_busy=0, shift left 8 and increment index.
REQ-028 TXWAIT exit: to IDLE after 16 bytes, otherwise back to SEND.
REQ-029 Byte order: MSB byte first (core_dout[127:120] first, [7:0] last).
REQ-030 Latency: pair_valid in IDLE produces core_start exactly 2 cycles later.
REQ-031 pair_valid while busy=1 and pend_v=0: store the pair in the slot.
REQ-032 pair_valid while busy=1 and pend_v=1: discard the pair; increment drop_cnt unless it is 255.
REQ-033 Outputs core_start and tx_start are never high in the same cycle.

Reset
REQ-034 Reset to IDLE with pend_v=0 and index=0.
REQ-035 Reset values: core_start=0, tx_start=0, tx_byte=0, core_din=0, core_key=0, busy=0, drop_cnt=0, timeout_err=0.
REQ-036 Reset mid-operation aborts immediately: remaining bytes and any pending pair are lost.
REQ-037 A pair_valid coincident with reset is ignored.

Configuration
REQ-038 Macro CSEQ_TIMEOUT_EN.
REQ-039 With CSEQ_TIMEOUT_EN defined: a cycle counter runs in WAIT.
REQ-040 On reaching TIMEOUT_CYCLES without core_done: set timeout_err (sticky until reset) and return to IDLE without transmitting.
REQ-041 Without CSEQ_TIMEOUT_EN: WAIT waits indefinitely; no counter logic is built; timeout_err is constant 0.

Verification
REQ-042 Single pair, core_done 10 cycles after core_start with core_dout=0x00112233...EEFF -> core_start 2 cycles after pair_valid; 16 tx_start pulses carrying 00,11,...,FF in order; busy returns to 0.
REQ-043 Three pairs back-to-back while busy -> second pair processed after the first; third dropped; drop_cnt=1.
REQ-044 tx_busy held high for 50 cycles per byte -> exactly one tx_start per byte; no byte skipped or repeated.
REQ-045 Reset asserted at byte 7 -> all outputs at reset values next cycle; no further tx_start pulses.
REQ-046 CSEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, core_done never asserted -> timeout_err=1 after 20 WAIT cycles; FSM in IDLE; no tx_start.
REQ-047 Spurious core_done pulse in IDLE -> no state change and no tx_start.

Source files
------------

// File: rtl/cipher_sequencer.sv
// cipher_sequencer: feeds msg/key pairs to a cipher core and streams each 128-bit result MSB byte first to a UART.
// Define CSEQ_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYCLES and raise a sticky timeout_err.
module cipher_sequencer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pair_valid,
  input  logic [127:0] msg,
  input  logic [127:0] key,
  input  logic         core_done,
  input  logic [127:0] core_dout,
  input  logic         tx_busy,
  output logic         core_start,
  output logic [127:0] core_din,
  output logic [127:0] core_key,
  output logic         tx_start,
  output logic [7:0]   tx_byte,
  output logic         busy,
  output logic [7:0]   drop_cnt,
  output logic         timeout_err
);
  typedef enum logic [2:0] {IDLE, START, WAIT, SEND, TXWAIT} state_e;
  state_e       state_q;
  logic         pend_v_q, first_q, core_start_q, tx_start_q;
  logic [127:0] pend_msg_q, pend_key_q, shift_q, core_din_q, core_key_q;
  logic [3:0]   idx_q;
  logic [7:0]   tx_byte_q, drop_q;
`ifdef CSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pend_v_q     <= 1'b0;
      pend_msg_q   <= '0;
      pend_key_q   <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      first_q      <= 1'b0;
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      core_din_q   <= '0;
      core_key_q   <= '0;
      drop_q       <= '0;
`ifdef CSEQ_TIMEOUT_EN
      tmo_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      core_start_q <= 1'b0;
      tx_start_q   <= 1'b0;
      if (pair_valid && state_q != IDLE) begin
        if (!pend_v_q) begin
          pend_v_q   <= 1'b1;
          pend_msg_q <= msg;
          pend_key_q <= key;
        end else if (drop_q != 8'hff) begin
          drop_q <= drop_q + 8'd1;
        end
      end
      case (state_q)
        IDLE: if (pend_v_q || pair_valid) begin
          // pending pair has priority; a coincident new pair takes over the slot
          core_din_q <= pend_v_q ? pend_msg_q : msg;
          core_key_q <= pend_v_q ? pend_key_q : key;
          pend_v_q   <= pend_v_q && pair_valid;
          if (pend_v_q) begin
            pend_msg_q <= msg;
            pend_key_q <= key;
          end
          state_q <= START;
        end
        START: begin
          core_start_q <= 1'b1;
          state_q      <= WAIT;
        end
        WAIT: if (core_done) begin
          shift_q <= core_dout;
          idx_q   <= '0;
          state_q <= SEND;
        end
`ifdef CSEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end
`endif
        SEND: if (!tx_busy) begin
          tx_byte_q  <= shift_q[127:120];
          tx_start_q <= 1'b1;
          first_q    <= 1'b1;
          state_q    <= TXWAIT;
        end
        TXWAIT: if (first_q) begin
          first_q <= 1'b0;
        end else if (!tx_busy) begin
          shift_q <= {shift_q[119:0], 8'h00};
          idx_q   <= idx_q + 4'd1;
          state_q <= idx_q == 4'd15 ? IDLE : SEND;
        end
        default: state_q <= IDLE;
      endcase
`ifdef CSEQ_TIMEOUT_EN
      tmo_q <= (state_q == WAIT && !core_done) ? tmo_q + 1'b1 : '0;
`endif
    end
  end
  assign core_start = core_start_q;
  assign core_din   = core_din_q;
  assign core_key   = core_key_q;
  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = state_q != IDLE;
  assign drop_cnt   = drop_q;
endmodule
